// File: rtl/multichannel_period_timer_pkg.sv
// Shared types and defaults for the multichannel period timer.
// Holds channel state encoding, mode encoding and default widths.
package multichannel_period_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEF_CNT_W  = 48;
    localparam int DEF_WORD_W = 16;

endpackage

// File: rtl/period_timer_ch.sv
// One down-counting period timer channel: staging shift register,
// start edge detect, IDLE/RUN FSM and down counter.
// Ports: clk, rst (async high), i_wr_en/i_wr_data (stage shift-in),
//   i_start, i_stop, i_mode (1 periodic, 0 one-shot),
//   o_tick_nxt (expiry seen this cycle, registered by the top), o_busy.
module period_timer_ch
    import multichannel_period_timer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode,
    output logic              o_tick_nxt,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_state_e        r_state;
    logic [CNT_W-1:0] r_stage;
    logic [CNT_W-1:0] r_count;
    logic             r_start_d;

    logic [CNT_W-1:0] w_stage_nxt;
    logic             w_start_edge;
    logic             w_run;
    logic             w_zero;

    generate
        if (CNT_W > WORD_W) begin : g_shift
            assign w_stage_nxt = {r_stage[CNT_W-WORD_W-1:0], i_wr_data};
        end else begin : g_word
            assign w_stage_nxt = i_wr_data;
        end
    endgenerate

    assign w_start_edge = i_start & ~r_start_d;
    assign w_run        = (r_state == ST_RUN);
    assign w_zero       = (r_count == '0);

    // Stop and restart both suppress the expiry of this cycle.
    assign o_tick_nxt = w_run & w_zero & ~i_stop & ~w_start_edge;
    assign o_busy     = w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_stage   <= '0;
            r_count   <= '0;
            // A start held high through reset must not arm.
            r_start_d <= 1'b1;
        end else begin
            r_start_d <= i_start;
            if (i_wr_en) begin
                r_stage <= w_stage_nxt;
            end
            if (i_stop) begin
                r_state <= ST_IDLE;
            end else if (w_start_edge) begin
                r_state <= ST_RUN;
                r_count <= r_stage;
            end else if (w_run) begin
                if (!w_zero) begin
                    r_count <= r_count - ONE;
                end else if (i_mode == MODE_PERIODIC) begin
                    r_count <= r_stage;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: rtl/multichannel_period_timer.sv
// N_CH independent period timers plus a free-running timestamp.
// Ports: clk, rst (async high), wr_en/wr_ch/wr_data (period load),
//   start/stop/mode per channel, tick/busy per channel, ts_en,
//   timestamp, ts_wrap, tick_ts (N_CH x CNT_W capture).
// Macro TIMER_TICK_CAPTURE_EN enables tick_ts capture; otherwise 0.
module multichannel_period_timer
    import multichannel_period_timer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int N_CH   = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       mode,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       busy,
    input  logic                  ts_en,
    output logic [CNT_W-1:0]      timestamp,
    output logic                  ts_wrap,
    output logic [N_CH*CNT_W-1:0] tick_ts
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [N_CH-1:0]  w_tick_nxt;
    logic [N_CH-1:0]  r_tick;
    logic [CNT_W-1:0] r_ts;
    logic             r_wrap;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic w_wr_sel;
            // Out-of-range channel indices match no channel.
            assign w_wr_sel = wr_en & (wr_ch == CH_W'(c));

            period_timer_ch #(
                .CNT_W  (CNT_W),
                .WORD_W (WORD_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_wr_en    (w_wr_sel),
                .i_wr_data  (wr_data),
                .i_start    (start[c]),
                .i_stop     (stop[c]),
                .i_mode     (mode[c]),
                .o_tick_nxt (w_tick_nxt[c]),
                .o_busy     (busy[c])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick_nxt;
        end
    end

    assign tick = r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts   <= '0;
            r_wrap <= 1'b0;
        end else if (ts_en) begin
            r_ts <= r_ts + ONE;
            if (&r_ts) begin
                r_wrap <= 1'b1;
            end
        end else begin
            r_ts   <= '0;
            r_wrap <= 1'b0;
        end
    end

    assign timestamp = r_ts;
    assign ts_wrap   = r_wrap;

`ifdef TIMER_TICK_CAPTURE_EN
    logic [N_CH*CNT_W-1:0] r_tick_ts;

    // Captured alongside the tick register, so the value is the
    // timestamp of the cycle in which the zero count was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_ts <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_tick_nxt[c]) begin
                    r_tick_ts[c*CNT_W +: CNT_W] <= r_ts;
                end
            end
        end
    end

    assign tick_ts = r_tick_ts;
`else
    assign tick_ts = '0;
`endif

endmodule

// File: tb/tb_multichannel_period_timer.sv
// Self-checking bench for multichannel_period_timer.
// Main instance 48/16/4; small instance 8/4/3 for wrap and decode.
module tb_multichannel_period_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         wr_en = 0;
    logic [1:0]   wr_ch = 0;
    logic [15:0]  wr_data = 0;
    logic [3:0]   start = 0, stop = 0, mode = 0;
    logic         ts_en = 0;
    logic [3:0]   tick, busy;
    logic [47:0]  timestamp;
    logic         ts_wrap;
    logic [191:0] tick_ts;

    logic         b_wr_en = 0;
    logic [1:0]   b_wr_ch = 0;
    logic [3:0]   b_wr_data = 0;
    logic [2:0]   b_start = 0, b_stop = 0, b_mode = 0;
    logic         b_ts_en = 0;
    logic [2:0]   b_tick, b_busy;
    logic [7:0]   b_timestamp;
    logic         b_ts_wrap;
    logic [23:0]  b_tick_ts;

    multichannel_period_timer #(
        .CNT_W(48), .WORD_W(16), .N_CH(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .start(start), .stop(stop), .mode(mode),
        .tick(tick), .busy(busy),
        .ts_en(ts_en), .timestamp(timestamp),
        .ts_wrap(ts_wrap), .tick_ts(tick_ts)
    );

    multichannel_period_timer #(
        .CNT_W(8), .WORD_W(4), .N_CH(3)
    ) u_ts (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_data(b_wr_data),
        .start(b_start), .stop(b_stop), .mode(b_mode),
        .tick(b_tick), .busy(b_busy),
        .ts_en(b_ts_en), .timestamp(b_timestamp),
        .ts_wrap(b_ts_wrap), .tick_ts(b_tick_ts)
    );

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] d;
        logic [3:0]  st;
        logic [3:0]  sp;
        logic [3:0]  md;
        logic        te;
        logic [3:0]  e_tick;
        logic [3:0]  e_busy;
        logic [47:0] e_ts;
        logic        c_tts;
        logic [47:0] e_tts;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [47:0] cap(input logic [47:0] v);
`ifdef TIMER_TICK_CAPTURE_EN
        return v;
`else
        return 48'd0 & v;
`endif
    endfunction

    function automatic vec_t mk(
        input logic we, input logic [1:0] ch, input logic [15:0] d,
        input logic [3:0] st, input logic [3:0] sp, input logic [3:0] md,
        input logic te, input logic [3:0] et, input logic [3:0] eb,
        input logic [47:0] ets, input logic ct, input logic [47:0] ett);
        vec_t v;
        v.we = we; v.ch = ch; v.d = d;
        v.st = st; v.sp = sp; v.md = md; v.te = te;
        v.e_tick = et; v.e_busy = eb; v.e_ts = ets;
        v.c_tts = ct; v.e_tts = ett;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        wr_en = v.we; wr_ch = v.ch; wr_data = v.d;
        start = v.st; stop = v.sp; mode = v.md; ts_en = v.te;
        @(posedge clk);
        #1;
        chk($sformatf("row%0d tick", idx), tick, v.e_tick);
        chk($sformatf("row%0d busy", idx), busy, v.e_busy);
        chk($sformatf("row%0d ts", idx), timestamp, v.e_ts);
        if (v.c_tts)
            chk($sformatf("row%0d tick_ts0", idx), tick_ts[47:0], v.e_tts);
    endtask

    initial begin
        // ch0 periodic P=4, stage rewritten to 7 mid-period, then stop
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0001, 0, 4'b0001, 0,
                         0, 4'b0001, 0, 0, 0));
        for (int n = 4; n <= 21; n++) begin
            tbl.push_back(mk(
                (n >= 9 && n <= 11), 0, (n == 11) ? 16'h0007 : 16'h0000,
                4'b0001, 0, 4'b0001, 1,
                (n == 8 || n == 13 || n == 21) ? 4'b0001 : 4'b0000,
                4'b0001, 48'(n - 3),
                (n == 8 || n == 13 || n == 21),
                cap((n == 8) ? 48'd4 : (n == 13) ? 48'd9 : 48'd17)));
        end
        tbl.push_back(mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1,
                         0, 0, 48'd19, 1, cap(48'd17)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        // ch1 one-shot P=2, held start, re-arm
        tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ch2 periodic P=0, then stop and stop-with-start-edge
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0,
                         0, 4'b0100, 0, 0, 0));
        for (int n = 0; n < 3; n++)
            tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0,
                             4'b0100, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0100, 4'b0100, 4'b0100, 0,
                         0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0100, 4'b0100, 4'b0100, 0,
                         0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst tick", tick, 0);
        chk("rst busy", busy, 0);
        chk("rst ts", timestamp, 0);
        chk("rst wrap", ts_wrap, 0);
        chk("rst tick_ts", tick_ts, 0);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

        // small instance: timestamp wrap and clear
        @(negedge clk);
        b_ts_en = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("b ts 255", b_timestamp, 8'd255);
        chk("b wrap pre", b_ts_wrap, 0);
        @(posedge clk); #1;
        chk("b ts wrap0", b_timestamp, 0);
        chk("b wrap set", b_ts_wrap, 1);
        @(posedge clk); #1;
        chk("b ts 1", b_timestamp, 1);
        chk("b wrap hold", b_ts_wrap, 1);
        @(negedge clk);
        b_ts_en = 1'b0;
        @(posedge clk); #1;
        chk("b ts clr", b_timestamp, 0);
        chk("b wrap clr", b_ts_wrap, 0);

        // small instance: out-of-range wr_ch ignored, ch2 P=3
        @(negedge clk);
        b_wr_en = 1; b_wr_ch = 2; b_wr_data = 4'h0;
        @(negedge clk);
        b_wr_data = 4'h3;
        @(negedge clk);
        b_wr_ch = 3; b_wr_data = 4'hF;
        @(negedge clk);
        b_wr_en = 0; b_start = 3'b111; b_mode = 3'b000;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            chk($sformatf("b tick j%0d", j), b_tick,
                (j == 1) ? 3'b011 : (j == 4) ? 3'b100 : 3'b000);
            chk($sformatf("b busy j%0d", j), b_busy,
                (j == 0) ? 3'b111 : (j < 4) ? 3'b100 : 3'b000);
        end

        // main instance: reset while running
        @(negedge clk);
        start = 4'b0101; mode = 4'b0101; stop = 0; ts_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre rst tick", tick, 4'b0100);
        chk("pre rst busy", busy, 4'b0101);
        chk("pre rst ts", timestamp, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst tick", tick, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst ts", timestamp, 0);
        chk("mid rst wrap", ts_wrap, 0);
        chk("mid rst tick_ts", tick_ts, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            chk($sformatf("post rst tick j%0d", j), tick, 0);
            chk($sformatf("post rst busy j%0d", j), busy, 0);
        end
        chk("post rst ts", timestamp, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multichannel_period_timer.md
Name: multichannel_period_timer

Overview:
- Parametrised successor to the single-channel period/timestamp block: N_CH independent down-counting period timers plus one free-running timestamp counter, all in one clock domain.
- Host logic loads periods as WORD_W-bit words into per-channel staging registers; start/stop controls run each channel in periodic or one-shot mode.
- One-cycle tick pulses feed the pulse/measurement sequencers; the timestamp is read alongside ticks.

Parameters:
- CNT_W, 48, counter/period/timestamp width; must be an integer multiple of WORD_W.
- WORD_W, 16, host load word width.
- N_CH, 4, number of timer channels, 1..16.
- CH_W, $clog2(N_CH) min 1, channel index width (localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  shift wr_data into staging register of channel wr_ch.
- wr_ch  in  CH_W  target channel for wr_en.
- wr_data  in  WORD_W  period word, MS word first.
- start  in  N_CH  per-channel level; rising edge arms/restarts the channel.
- stop  in  N_CH  per-channel level; forces channel idle while high.
- mode  in  N_CH  per-channel: 1 = periodic, 0 = one-shot; sampled at each zero-count.
- tick  out  N_CH  one-cycle pulse per expiry, registered.
- busy  out  N_CH  channel in RUN.
- ts_en  in  1  timestamp count enable; low synchronously clears the timestamp.
- timestamp  out  CNT_W  free-running timestamp.
- ts_wrap  out  1  sticky: timestamp wrapped since ts_en rose.
- tick_ts  out  N_CH*CNT_W  timestamp captured at each channel's last tick (see optional feature).

Behaviour:
- Reset: stage, count, tick, busy, timestamp, ts_wrap, tick_ts = 0; all channels IDLE; start_d = all ones, so a start held high through reset does not arm.
- Staging: on wr_en, stage[wr_ch] <= {stage[wr_ch][CNT_W-WORD_W-1:0], wr_data}. Writing CNT_W/WORD_W words loads a full period P. Extra writes keep shifting. wr_ch >= N_CH is ignored.
- Edge detect: start_edge = start & ~start_d; start_d <= start every cycle.
- Per-channel FSM, states IDLE and RUN:
  - IDLE -> RUN on start_edge & ~stop; count <= stage.
  - RUN, count != 0: count <= count-1.
  - RUN, count == 0: tick <= 1 next edge. If mode = 1, count <= stage and stay in RUN. If mode = 0, go to IDLE.
  - RUN, start_edge & ~stop: restart with count <= stage; no tick that cycle even if count == 0.
  - Any state, stop = 1: go to IDLE, count held, no tick; stop beats start_edge in the same cycle.
- Timing: start_edge sampled at edge k gives ticks high in the cycle after edges k+P+1, k+2(P+1), and so on.
  - Tick spacing is P+1 cycles.
  - P = 0 in periodic mode ticks every cycle.
- Reload uses the registered stage value; wr_en in the reload cycle affects only the next reload. Period changes while running take effect at the next reload.
- busy = (state == RUN).
- Timestamp:
  - ts_en = 1: timestamp increments, wrapping at 2^CNT_W; on wrap, ts_wrap <= 1.
  - ts_en = 0: timestamp <= 0 and ts_wrap <= 0.
- Channels are fully independent; simultaneous ticks on several channels are allowed.

Optional Feature:
- Macro TIMER_TICK_CAPTURE_EN.
- Defined: on each tick of channel c, tick_ts[c*CNT_W +: CNT_W] <= timestamp value in the cycle count==0 was seen, which equals timestamp at the tick-high cycle minus 1. Value holds until the next tick of that channel; reset 0.
- Undefined: tick_ts is driven constant 0 and no capture registers are synthesised. The port is always present.

Decomposition:
- Shared package: channel state encoding (ST_IDLE, ST_RUN), mode encoding (MODE_ONESHOT, MODE_PERIODIC), default CNT_W/WORD_W constants.
- Natural sub-module period_timer_ch: one channel's stage shift register, edge detect, FSM and down counter; instantiated N_CH times in a generate loop. The top holds the timestamp counter, wr_ch decode and tick_ts capture.

Test Plan:
- Load ch0 with words 0x0000,0x0000,0x0004 (P=4), mode=1, start rises at edge k -> tick[0] high after edges k+5, k+10, k+15; busy[0]=1 throughout.
- Load ch1 with P=2, mode=0, start edge -> exactly one tick[1] after edge k+3, then busy[1]=0; start held high produces no further ticks; low-then-high re-arms.
- ch2 P=0, periodic -> tick[2] high every cycle. Assert stop[2] and start edge in the same cycle -> stays IDLE, tick[2]=0.
- ch0 running with P=4, rewrite stage to 7 mid-period -> current period completes at 5 cycles, following spacing 8. Assert rst mid-run -> all outputs 0 immediately, no tick after release.
- ts_en=1 with timestamp forced near 2^CNT_W-1 (CNT_W=16 build) -> wraps to 0, ts_wrap=1; ts_en=0 -> timestamp=0, ts_wrap=0.
- TIMER_TICK_CAPTURE_EN defined, ts_en=1 from edge 0, ch0 P=4 started at edge 0 -> tick_ts[0] = 4 at the first tick; with the macro undefined, tick_ts stays 0.
